// File: rtl/input_buffer_pkg.sv
// Shared parameters and packet FSM encoding
// for the router input buffer.
package input_buffer_pkg;

  localparam int TAM_FLIT   = 16;
  localparam int TAM_BUFFER = 4;

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_HEADER     = 3'd1,
    S_SENDHEADER = 3'd2,
    S_SIZE       = 3'd3,
    S_PAYLOAD    = 3'd4,
    S_END        = 3'd5
  } state_t;

endpackage

// File: rtl/input_buffer_fifo_circ.sv
// Circular flit FIFO: storage, pointers,
// occupancy count and zero-masked head.
module input_buffer_fifo_circ
  import input_buffer_pkg::*;
#(
  parameter int W     = TAM_FLIT,
  parameter int DEPTH = TAM_BUFFER
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign head  = empty ? '0 : mem[rd_ptr];

  // power-of-2 depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/input_buffer.sv
// Router per-port input stage: FIFO plus
// packet FSM driving the crossbar lanes.
module input_buffer
  import input_buffer_pkg::*;
#(
  parameter int FLIT_W = TAM_FLIT,
  parameter int DEPTH  = TAM_BUFFER
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx,
  input  logic [FLIT_W-1:0] i_data_in,
  output logic              o_credit,
  output logic              o_h,
  input  logic              i_ack_h,
  output logic              o_data_av,
  output logic [FLIT_W-1:0] o_data,
  input  logic              i_data_ack,
  output logic              o_sender
);

  localparam logic [FLIT_W-1:0] CNT_ONE = FLIT_W'(1);

  state_t            state;
  state_t            state_nx;
  logic [FLIT_W-1:0] flit_cnt;
  logic [FLIT_W-1:0] flit_cnt_nx;
  logic [FLIT_W-1:0] head;
  logic              full;
  logic              empty;
  logic              pop;

  input_buffer_fifo_circ #(
    .W     (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (i_rx),
    .pop   (pop),
    .din   (i_data_in),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign o_credit  = !full;
  assign o_data    = head;
  assign o_data_av = !empty &&
    (state inside {S_SENDHEADER, S_SIZE, S_PAYLOAD});
  assign pop       = o_data_av && i_data_ack;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_INIT;
      flit_cnt <= '0;
    end else begin
      state    <= state_nx;
      flit_cnt <= flit_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    flit_cnt_nx = flit_cnt;
    o_h         = 1'b0;
    o_sender    = 1'b0;
    unique case (state)
      S_INIT: begin
        if (!empty) state_nx = S_HEADER;
      end
      S_HEADER: begin
        o_h = 1'b1;
        if (i_ack_h) state_nx = S_SENDHEADER;
      end
      S_SENDHEADER: begin
        o_sender = 1'b1;
        if (pop) state_nx = S_SIZE;
      end
      S_SIZE: begin
        o_sender = 1'b1;
        if (pop) begin
          flit_cnt_nx = head;
          state_nx    = (head == '0) ? S_END : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        o_sender = 1'b1;
        if (pop) begin
          flit_cnt_nx = flit_cnt - CNT_ONE;
          if (flit_cnt == CNT_ONE) state_nx = S_END;
        end
      end
      default: state_nx = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_input_buffer.sv
// Self-checking bench for input_buffer:
// vector table, directed corners, random stream.
module tb_input_buffer;

  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_rx = 1'b0;
  logic [15:0] i_data_in = '0;
  logic        o_credit;
  logic        o_h;
  logic        i_ack_h = 1'b0;
  logic        o_data_av;
  logic [15:0] o_data;
  logic        i_data_ack = 1'b0;
  logic        o_sender;

  int n_chk = 0;
  int n_fail = 0;

  input_buffer dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rx       (i_rx),
    .i_data_in  (i_data_in),
    .o_credit   (o_credit),
    .o_h        (o_h),
    .i_ack_h    (i_ack_h),
    .o_data_av  (o_data_av),
    .o_data     (o_data),
    .i_data_ack (i_data_ack),
    .o_sender   (o_sender)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rx;
    logic [15:0] din;
    logic        ack_h;
    logic        dack;
    logic        h;
    logic        av;
    logic        snd;
    logic        cr;
    logic [15:0] dat;
  } vec_t;

  vec_t tbl[$];
  logic [15:0] src[$];

  function automatic vec_t mk(
    input logic rx, input logic [15:0] din,
    input logic ack_h, input logic dack,
    input logic h, input logic av,
    input logic snd, input logic cr,
    input logic [15:0] dat);
    vec_t v;
    v.rx = rx; v.din = din;
    v.ack_h = ack_h; v.dack = dack;
    v.h = h; v.av = av; v.snd = snd;
    v.cr = cr; v.dat = dat;
    return v;
  endfunction

  task automatic chk(input string nm,
    input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
        nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle_in();
    i_rx = 1'b0;
    i_data_in = '0;
    i_ack_h = 1'b0;
    i_data_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    i_rst_n = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_h"}, o_h, 0);
    chk({nm, "_av"}, o_data_av, 0);
    chk({nm, "_snd"}, o_sender, 0);
    chk({nm, "_cr"}, o_credit, 1);
    chk({nm, "_dat"}, o_data, 0);
  endtask

  // Stream model: FIFO as a queue, packet phase
  // derived from header/size/payload framing.
  task automatic run_stream(input int mode,
    input int budget);
    logic [15:0] q[$];
    logic [15:0] got[$];
    logic [15:0] f;
    int idx = 0;
    int cyc = 0;
    int pidx = 0;
    int plen = 0;
    bit granted = 0;
    bit pop, push, grant;
    while (got.size() < src.size() && cyc < budget) begin
      chk("s_credit", o_credit, q.size() != DEPTH);
      chk("s_data", o_data,
        (q.size() != 0) ? 32'(q[0]) : 32'd0);
      chk("s_sender", o_sender, granted);
      chk("s_av", o_data_av, granted && q.size() != 0);
      if (o_h) chk("s_h_when", granted || q.size() == 0, 0);
      if (mode == 0) begin
        i_rx = (idx < src.size()) && (cyc % 3 != 2);
        i_data_ack = (cyc % 2 == 0);
        i_ack_h = o_h;
      end else begin
        i_rx = (idx < src.size()) &&
          ($urandom_range(0, 3) != 0);
        i_data_ack = ($urandom_range(0, 2) != 0);
        i_ack_h = 1'($urandom_range(0, 1));
      end
      i_data_in = (idx < src.size()) ? src[idx]
                                    : 16'($urandom);
      pop = o_data_av && i_data_ack;
      push = i_rx && (q.size() < DEPTH);
      grant = o_h && i_ack_h;
      if (pop && q.size() != 0) begin
        f = q.pop_front();
        got.push_back(f);
        if (granted) begin
          if (pidx == 1) plen = int'(f);
          pidx++;
          if (pidx >= 2 && pidx == plen + 2) granted = 0;
        end
      end
      if (push) begin
        q.push_back(src[idx]);
        idx++;
      end
      if (grant) begin
        granted = 1;
        pidx = 0;
      end
      step();
      cyc++;
    end
    chk("s_done", got.size(), src.size());
    for (int i = 0; i < got.size() && i < src.size(); i++)
      chk("s_order", got[i], src[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // single packet
    tbl.push_back(mk(1,16'h0011,0,1, 0,0,0,1,16'h0011));
    tbl.push_back(mk(1,16'h0002,0,1, 1,0,0,1,16'h0011));
    tbl.push_back(mk(1,16'hAAAA,1,1, 0,1,1,1,16'h0011));
    tbl.push_back(mk(1,16'hBBBB,0,1, 0,1,1,1,16'h0002));
    tbl.push_back(mk(0,16'h0000,0,1, 0,1,1,1,16'hAAAA));
    tbl.push_back(mk(0,16'h0000,0,1, 0,1,1,1,16'hBBBB));
    tbl.push_back(mk(0,16'h0000,0,1, 0,0,0,1,16'h0000));
    tbl.push_back(mk(0,16'h0000,0,1, 0,0,0,1,16'h0000));
    // full / credit, 5th flit dropped
    tbl.push_back(mk(1,16'h0033,0,0, 0,0,0,1,16'h0033));
    tbl.push_back(mk(1,16'h0002,0,0, 1,0,0,1,16'h0033));
    tbl.push_back(mk(1,16'h1111,0,0, 1,0,0,1,16'h0033));
    tbl.push_back(mk(1,16'h2222,0,0, 1,0,0,0,16'h0033));
    tbl.push_back(mk(1,16'h9999,0,0, 1,0,0,0,16'h0033));
    tbl.push_back(mk(0,16'h0000,1,0, 0,1,1,0,16'h0033));
    tbl.push_back(mk(0,16'h0000,0,1, 0,1,1,1,16'h0002));
    tbl.push_back(mk(0,16'h0000,0,1, 0,1,1,1,16'h1111));
    tbl.push_back(mk(0,16'h0000,0,1, 0,1,1,1,16'h2222));
    tbl.push_back(mk(0,16'h0000,0,1, 0,0,0,1,16'h0000));
    tbl.push_back(mk(0,16'h0000,0,0, 0,0,0,1,16'h0000));
    // zero-length packets back to back
    tbl.push_back(mk(1,16'h0022,0,1, 0,0,0,1,16'h0022));
    tbl.push_back(mk(1,16'h0000,0,1, 1,0,0,1,16'h0022));
    tbl.push_back(mk(1,16'h0044,1,1, 0,1,1,1,16'h0022));
    tbl.push_back(mk(1,16'h0000,0,1, 0,1,1,1,16'h0000));
    tbl.push_back(mk(0,16'h0000,0,1, 0,0,0,1,16'h0044));
    tbl.push_back(mk(0,16'h0000,0,1, 0,0,0,1,16'h0044));
    tbl.push_back(mk(0,16'h0000,0,1, 1,0,0,1,16'h0044));
    tbl.push_back(mk(0,16'h0000,1,1, 0,1,1,1,16'h0044));
    tbl.push_back(mk(0,16'h0000,0,1, 0,1,1,1,16'h0000));
    tbl.push_back(mk(0,16'h0000,0,1, 0,0,0,1,16'h0000));
    tbl.push_back(mk(0,16'h0000,0,1, 0,0,0,1,16'h0000));

    do_reset();
    chk_idle("reset");

    foreach (tbl[i]) begin
      i_rx = tbl[i].rx;
      i_data_in = tbl[i].din;
      i_ack_h = tbl[i].ack_h;
      i_data_ack = tbl[i].dack;
      step();
      chk($sformatf("v%0d_h", i), o_h, tbl[i].h);
      chk($sformatf("v%0d_av", i), o_data_av, tbl[i].av);
      chk($sformatf("v%0d_snd", i), o_sender, tbl[i].snd);
      chk($sformatf("v%0d_cr", i), o_credit, tbl[i].cr);
      chk($sformatf("v%0d_dat", i), o_data, tbl[i].dat);
    end
    idle_in();

    // reset in the middle of a payload
    i_rx = 1'b1;
    i_data_in = 16'h0055; step();
    i_data_in = 16'h0005; step();
    i_data_in = 16'hA001; step();
    i_data_in = 16'hA002; step();
    i_rx = 1'b0;
    chk("mid_h", o_h, 1);
    i_ack_h = 1'b1; step();
    i_ack_h = 1'b0;
    i_data_ack = 1'b1;
    i_rx = 1'b1;
    i_data_in = 16'hA003; step();
    i_data_in = 16'hA004; step();
    i_rx = 1'b0; step();
    i_data_ack = 1'b0;
    chk("mid_snd", o_sender, 1);
    chk("mid_av", o_data_av, 1);
    chk("mid_dat", o_data, 16'hA002);
    #3 i_rst_n = 1'b0;
    #1 chk_idle("async");
    @(negedge i_clk) i_rst_n = 1'b1;
    step();
    chk_idle("flush");
    step();
    chk("flush2_h", o_h, 0);

    // stall and wrap: 8-flit payload
    do_reset();
    src.delete();
    src.push_back(16'h0066);
    src.push_back(16'h0008);
    for (int i = 0; i < 8; i++)
      src.push_back(16'h5000 + 16'(i));
    run_stream(0, 400);
    idle_in();

    // randomized packet stream
    do_reset();
    src.delete();
    for (int p = 0; p < 25; p++) begin
      int len;
      len = $urandom_range(0, 5);
      src.push_back(16'($urandom));
      src.push_back(16'(len));
      for (int k = 0; k < len; k++)
        src.push_back(16'($urandom));
    end
    run_stream(1, 4000);
    idle_in();
    step();
    chk("end_snd", o_sender, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
